// File: rtl/mips_cpu_regfile_sb.sv
// mips_cpu_regfile_sb
// General-purpose register file with an integrated pending-write scoreboard.
// Register 0 is hardwired to zero and can never be marked pending.
//
// Optional feature: define REGFILE_BYPASS_EN to forward the write data
// combinationally to RsDATA/RtDATA/register_v0 when the read index matches
// a write being presented in the same cycle. Busy flags are never bypassed.
//
// Ports:
//   clk          rising-edge clock
//   RESET        synchronous active-high reset (clears registers and pend bits)
//   WENREG/Rd/RdDATA     write port; a write also clears pend[Rd]
//   Rs/Rt -> RsDATA/RtDATA   combinational read ports
//   register_v0  contents of register DBG_REG
//   PEND_SET/PEND_Rd     marks a register as awaiting a multi-cycle result
//   Rs_busy/Rt_busy      combinational pend lookup for Rs/Rt
//   busy_count   registered number of pending registers
module mips_cpu_regfile_sb #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DBG_REG = 2
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              WENREG,
    input  logic [ADDR_W-1:0] Rd,
    input  logic [DATA_W-1:0] RdDATA,
    input  logic [ADDR_W-1:0] Rs,
    input  logic [ADDR_W-1:0] Rt,
    output logic [DATA_W-1:0] RsDATA,
    output logic [DATA_W-1:0] RtDATA,
    output logic [DATA_W-1:0] register_v0,
    input  logic              PEND_SET,
    input  logic [ADDR_W-1:0] PEND_Rd,
    output logic              Rs_busy,
    output logic              Rt_busy,
    output logic [ADDR_W:0]   busy_count
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] DBG_IDX = ADDR_W'(DBG_REG);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pend;
    logic [DEPTH-1:0]  pend_nxt;
    logic [CNT_W-1:0]  pend_cnt_nxt;
    logic              wr_en;
    logic              set_en;

    assign wr_en  = WENREG && (Rd != '0);
    assign set_en = PEND_SET && (PEND_Rd != '0);

    // Next pend vector: a write clears, a set marks; set is applied last so it
    // wins when both target the same register (new load over completing one).
    always_comb begin
        pend_nxt = pend;
        if (wr_en) begin
            pend_nxt[Rd] = 1'b0;
        end
        if (set_en) begin
            pend_nxt[PEND_Rd] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    // Popcount of the next pend vector; bit 0 is always clear so it fits.
    always_comb begin
        pend_cnt_nxt = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            pend_cnt_nxt = pend_cnt_nxt + CNT_W'(pend_nxt[i]);
        end
    end

    // Register storage.
    always_ff @(posedge clk) begin
        if (RESET) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[ADDR_W'(i)] <= '0;
            end
        end else if (wr_en) begin
            regs[Rd] <= RdDATA;
        end
    end

    // Scoreboard state and its registered population count.
    always_ff @(posedge clk) begin
        if (RESET) begin
            pend       <= '0;
            busy_count <= '0;
        end else begin
            pend       <= pend_nxt;
            busy_count <= pend_cnt_nxt;
        end
    end

    // Read data for one index, with optional same-cycle write forwarding.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] idx);
        logic [DATA_W-1:0] val;
        if (idx == '0) begin
            val = '0;
        end else begin
            val = regs[idx];
`ifdef REGFILE_BYPASS_EN
            if (wr_en && (Rd == idx)) begin
                val = RdDATA;
            end
`endif
        end
        return val;
    endfunction

    always_comb begin
        RsDATA      = read_port(Rs);
        RtDATA      = read_port(Rt);
        register_v0 = read_port(DBG_IDX);
        Rs_busy     = pend[Rs];
        Rt_busy     = pend[Rt];
    end

endmodule

// File: tb/tb_mips_cpu_regfile_sb.sv
module tb_mips_cpu_regfile_sb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        RESET, WENREG, PEND_SET;
    logic [4:0]  Rd, Rs, Rt, PEND_Rd;
    logic [31:0] RdDATA, RsDATA, RtDATA, register_v0;
    logic        Rs_busy, Rt_busy;
    logic [5:0]  busy_count;

    int n_cmp = 0;
    int n_err = 0;

    mips_cpu_regfile_sb #(.DATA_W(32), .ADDR_W(5), .DBG_REG(2)) dut (
        .clk(clk), .RESET(RESET), .WENREG(WENREG), .Rd(Rd), .RdDATA(RdDATA),
        .Rs(Rs), .Rt(Rt), .RsDATA(RsDATA), .RtDATA(RtDATA),
        .register_v0(register_v0), .PEND_SET(PEND_SET), .PEND_Rd(PEND_Rd),
        .Rs_busy(Rs_busy), .Rt_busy(Rt_busy), .busy_count(busy_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic [4:0]  rd;
        logic [31:0] dat;
        logic        pset;
        logic [4:0]  prd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] ers;
        logic [31:0] ert;
        logic [31:0] ev0;
        logic        ersb;
        logic        ertb;
        logic [5:0]  ecnt;
    } vec_t;

    vec_t tbl [9];

    // Reference model state
    logic [31:0] m_reg  [32];
    bit          m_pend [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic wen, input logic [4:0] rd, input logic [31:0] dat,
                         input logic pset, input logic [4:0] prd,
                         input logic [4:0] rs, input logic [4:0] rt);
        WENREG = wen; Rd = rd; RdDATA = dat;
        PEND_SET = pset; PEND_Rd = prd; Rs = rs; Rt = rt;
    endtask

    task automatic idle(input logic [4:0] rs, input logic [4:0] rt);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, rs, rt);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        idle(5'd0, 5'd0);
        tick();
        RESET = 1'b0;
    endtask

    function automatic vec_t mk(input logic wen, input logic [4:0] rd, input logic [31:0] dat,
                                input logic pset, input logic [4:0] prd,
                                input logic [4:0] rs, input logic [4:0] rt,
                                input logic [31:0] ers, input logic [31:0] ert,
                                input logic [31:0] ev0, input logic ersb,
                                input logic ertb, input logic [5:0] ecnt);
        vec_t v;
        v.wen = wen; v.rd = rd; v.dat = dat; v.pset = pset; v.prd = prd;
        v.rs = rs; v.rt = rt; v.ers = ers; v.ert = ert; v.ev0 = ev0;
        v.ersb = ersb; v.ertb = ertb; v.ecnt = ecnt;
        return v;
    endfunction

    // Expected read value from the model, following the read/bypass rules.
    function automatic logic [31:0] m_read(input logic [4:0] idx, input logic wen,
                                           input logic [4:0] rd, input logic [31:0] dat);
        if (idx == 5'd0) return 32'd0;
        if (BYP && wen && rd == idx) return dat;
        return m_reg[idx];
    endfunction

    function automatic logic [5:0] m_count();
        int c = 0;
        for (int i = 0; i < 32; i++) if (m_pend[i]) c++;
        return 6'(c);
    endfunction

    initial begin
        logic        r_wen, r_pset, r_rst;
        logic [4:0]  r_rd, r_prd, r_rs, r_rt;
        logic [31:0] r_dat;

        RESET = 1'b0;
        idle(5'd0, 5'd0);

        // Reads are checked before each edge; state reflects earlier rows.
        tbl[0] = mk(0, 0, 0,            0, 0, 2, 31, 0, 0, 0, 0, 0, 0);
        tbl[1] = mk(1, 2, 49,           0, 0, 3, 31, 0, 0, BYP ? 32'd49 : 32'd0, 0, 0, 0);
        tbl[2] = mk(1, 0, 32'hDEADBEEF, 1, 0, 2, 3,  49, 0, 49, 0, 0, 0);
        tbl[3] = mk(0, 0, 0,            1, 3, 0, 2,  0, 49, 49, 0, 0, 0);
        tbl[4] = mk(1, 3, 38025,        0, 0, 3, 0,  BYP ? 32'd38025 : 32'd0, 0, 49, 1, 0, 1);
        tbl[5] = mk(1, 5, 32'h55,       1, 5, 3, 5,  38025, BYP ? 32'h55 : 32'd0, 49, 0, 0, 0);
        tbl[6] = mk(1, 7, 32'h77,       1, 6, 5, 6,  32'h55, 0, 49, 1, 0, 1);
        tbl[7] = mk(0, 0, 0,            0, 0, 6, 7,  0, 32'h77, 49, 1, 0, 2);
        tbl[8] = mk(0, 0, 0,            0, 0, 0, 0,  0, 0, 49, 0, 0, 2);

        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].wen, tbl[i].rd, tbl[i].dat, tbl[i].pset, tbl[i].prd, tbl[i].rs, tbl[i].rt);
            #4;
            chk($sformatf("tbl%0d_rsdata", i), RsDATA, tbl[i].ers);
            chk($sformatf("tbl%0d_rtdata", i), RtDATA, tbl[i].ert);
            chk($sformatf("tbl%0d_v0", i), register_v0, tbl[i].ev0);
            chk($sformatf("tbl%0d_rsbusy", i), 32'(Rs_busy), 32'(tbl[i].ersb));
            chk($sformatf("tbl%0d_rtbusy", i), 32'(Rt_busy), 32'(tbl[i].ertb));
            chk($sformatf("tbl%0d_count", i), 32'(busy_count), 32'(tbl[i].ecnt));
            tick();
        end

        // Bypass: same-cycle read of the register being written.
        do_reset();
        drive(1, 5'd4, 32'd7, 0, 5'd0, 5'd4, 5'd4);
        #4;
        chk("byp_pre_rs", RsDATA, BYP ? 32'd7 : 32'd0);
        chk("byp_pre_rt", RtDATA, BYP ? 32'd7 : 32'd0);
        tick();
        idle(5'd4, 5'd0);
        #4;
        chk("byp_post_rs", RsDATA, 32'd7);

        // Reset has priority over a simultaneous write and pending set.
        RESET = 1'b1;
        drive(1, 5'd8, 32'd9, 1, 5'd8, 5'd8, 5'd4);
        tick();
        RESET = 1'b0;
        idle(5'd8, 5'd4);
        #4;
        chk("rstpri_data", RsDATA, 32'd0);
        chk("rstpri_old", RtDATA, 32'd0);
        chk("rstpri_busy", 32'(Rs_busy), 32'd0);
        chk("rstpri_count", 32'(busy_count), 32'd0);

        // Reset mid-operation discards three pending marks.
        drive(1, 5'd10, 32'd100, 1, 5'd9, 5'd0, 5'd0);  tick();
        drive(0, 5'd0, 32'd0, 1, 5'd10, 5'd0, 5'd0);     tick();
        drive(0, 5'd0, 32'd0, 1, 5'd11, 5'd0, 5'd0);     tick();
        idle(5'd9, 5'd11);
        #4;
        chk("mid_count3", 32'(busy_count), 32'd3);
        chk("mid_busy9", 32'(Rs_busy), 32'd1);
        do_reset();
        idle(5'd9, 5'd10);
        #4;
        chk("mid_count0", 32'(busy_count), 32'd0);
        chk("mid_busy9_clr", 32'(Rs_busy), 32'd0);
        chk("mid_busy10_clr", 32'(Rt_busy), 32'd0);
        chk("mid_data10_clr", RtDATA, 32'd0);
        drive(1, 5'd9, 32'd5, 0, 5'd0, 5'd9, 5'd9);
        tick();
        idle(5'd9, 5'd9);
        #4;
        chk("mid_wr9_data", RsDATA, 32'd5);
        chk("mid_wr9_busy", 32'(Rs_busy), 32'd0);
        chk("mid_wr9_count", 32'(busy_count), 32'd0);

        // Randomised run against the reference model.
        do_reset();
        for (int i = 0; i < 32; i++) begin
            m_reg[i] = 32'd0;
            m_pend[i] = 1'b0;
        end
        for (int n = 0; n < 600; n++) begin
            r_rst  = ($urandom_range(0, 59) == 0);
            r_wen  = 1'($urandom_range(0, 1));
            r_pset = ($urandom_range(0, 2) == 0);
            // Narrow index range half the time to provoke collisions.
            r_rd   = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 6)) : 5'($urandom);
            r_prd  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 6)) : 5'($urandom);
            r_rs   = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 6)) : 5'($urandom);
            r_rt   = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 6)) : 5'($urandom);
            r_dat  = $urandom;
            RESET  = r_rst;
            drive(r_wen, r_rd, r_dat, r_pset, r_prd, r_rs, r_rt);
            #4;
            chk("rnd_rsdata", RsDATA, m_read(r_rs, r_wen, r_rd, r_dat));
            chk("rnd_rtdata", RtDATA, m_read(r_rt, r_wen, r_rd, r_dat));
            chk("rnd_v0", register_v0, m_read(5'd2, r_wen, r_rd, r_dat));
            chk("rnd_rsbusy", 32'(Rs_busy), 32'(m_pend[r_rs]));
            chk("rnd_rtbusy", 32'(Rt_busy), 32'(m_pend[r_rt]));
            chk("rnd_count", 32'(busy_count), 32'(m_count()));
            tick();
            if (r_rst) begin
                for (int i = 0; i < 32; i++) begin
                    m_reg[i] = 32'd0;
                    m_pend[i] = 1'b0;
                end
            end else begin
                if (r_wen && r_rd != 5'd0) begin
                    m_reg[r_rd] = r_dat;
                    m_pend[r_rd] = 1'b0;
                end
                if (r_pset && r_prd != 5'd0) m_pend[r_prd] = 1'b1;
            end
        end
        RESET = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mips_cpu_regfile_sb.md
# mips_cpu_regfile_sb

Parametrised general-purpose register file for the MIPS CPU datapath with an integrated pending-write scoreboard. It provides two asynchronous read ports and one synchronous write port, with register 0 hardwired to zero. It also tracks registers awaiting a multi-cycle result, such as a load or a multiply/divide writeback, so the decode stage can stall on RAW hazards. It sits between decode (Rs/Rt lookup) and writeback (Rd commit), and replaces the fixed 32x32 register file.

## Interface
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; depth is 2**ADDR_W.
- DBG_REG, 2, index mirrored on register_v0 (default $v0).
- clk  in  1  single clock; all state updates on rising edge.
- RESET  in  1  reset, synchronous and active-high.
- WENREG  in  1  write enable for Rd/RdDATA.
- Rd  in  ADDR_W  write index.
- RdDATA  in  DATA_W  write data.
- Rs  in  ADDR_W  read port A index.
- Rt  in  ADDR_W  read port B index.
- RsDATA  out  DATA_W  contents of Rs.
- RtDATA  out  DATA_W  contents of Rt.
- register_v0  out  DATA_W  contents of DBG_REG.
- PEND_SET  in  1  mark PEND_Rd as awaiting a result.
- PEND_Rd  in  ADDR_W  index to mark pending.
- Rs_busy  out  1  Rs currently pending.
- Rt_busy  out  1  Rt currently pending.
- busy_count  out  ADDR_W+1  number of pending registers.

## Operation
- Storage: 2**ADDR_W x DATA_W registers plus a 2**ADDR_W-bit pending vector.
- Register 0:
  - Writes to it are ignored.
  - Reads of it return 0.
  - PEND_SET to it is ignored, so its busy bit is always 0.
- Write: when WENREG=1 and Rd!=0, reg[Rd] <= RdDATA at the edge, and pend[Rd] is cleared.
- Pending set: when PEND_SET=1 and PEND_Rd!=0, pend[PEND_Rd] <= 1 at the edge.
- Write and set to the same index in the same cycle: the set wins (pend=1) and the data is still written. This models a new load issued over the completing one.
- Write and set to different indices in the same cycle: both take effect.
- Reads are combinational: RsDATA=reg[Rs], RtDATA=reg[Rt], Rs_busy=pend[Rs], Rt_busy=pend[Rt].
- busy_count is the registered popcount of pend after each update. It never exceeds 2**ADDR_W-1.
- RESET=1:
  - At the edge, all registers and all pend bits go to 0.
  - RESET has priority over WENREG and PEND_SET in the same cycle.
- Reset mid-operation: any outstanding pending marks are discarded. A later write to a previously pending register is an ordinary write.

## Timing
- Reset values: RsDATA, RtDATA, register_v0 = 0; Rs_busy, Rt_busy = 0; busy_count = 0.
- Write latency:
  - New data is visible on the read ports immediately after the writing edge.
  - With bypass enabled (see Configuration), it is also visible in the same cycle the write is presented.
- Pending latency: busy rises the cycle after PEND_SET and falls the cycle after the clearing write.
- The bypass never applies to the busy outputs: a read of Rd during its clearing-write cycle still reports busy=1.
- No handshake back-pressure: every cycle accepts one write and one pending set.

## Configuration
- REGFILE_BYPASS_EN defined:
  - When WENREG=1, Rd!=0 and Rd==Rs, RsDATA=RdDATA combinationally. The same rule applies to Rt and DBG_REG.
  - This gives same-cycle write-to-read forwarding for a single-cycle writeback.
- REGFILE_BYPASS_EN undefined: read ports show stored contents only, so a same-cycle read returns the old value.

## Test plan
- RESET=1 for one edge, then read Rs=2, Rt=31 -> RsDATA=0, RtDATA=0, register_v0=0, busy_count=0.
- Write Rd=2, RdDATA=49, then read Rs=2, Rt=3 on the next cycle -> RsDATA=49, RtDATA=0, register_v0=49.
- WENREG=1, Rd=0, RdDATA=0xDEADBEEF; also PEND_SET with PEND_Rd=0 -> Rs=0 reads 0, Rs_busy=0, busy_count=0.
- Pending sequence:
  - PEND_SET with PEND_Rd=3 -> Rs=3 gives Rs_busy=1 next cycle, busy_count=1.
  - Then write Rd=3, RdDATA=38025 -> after the edge, Rs_busy=0, RsDATA=38025, busy_count=0.
- Same-cycle write and set:
  - Same index: WENREG Rd=5 with PEND_SET PEND_Rd=5 -> pend[5]=1, reg[5] written.
  - Different indices: PEND_Rd=6 with a write to 5 -> busy_count incremented by one.
- Bypass: with REGFILE_BYPASS_EN, present WENREG Rd=4, RdDATA=7, Rs=4 -> RsDATA=7 before the edge. Without it -> RsDATA=0 before the edge, 7 after.
- Reset mid-operation: pend 3 registers (busy_count=3), assert RESET one cycle -> busy_count=0, all reads 0, all busy=0.
